// File: rtl/noc_flit_pkg.sv
// noc_flit_pkg: flit field layout and type codes shared by leaf uplinks and the spine routing FSM
package noc_flit_pkg;
    localparam int FLIT_DWIDTH = 16;
    localparam int FTYPE_MSB = 15;
    localparam int FTYPE_LSB = 14;
    localparam int DEST_MSB = 13;
    localparam int DEST_LSB = 8;
    typedef enum logic [1:0] {
        FLIT_SINGLE = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_BODY   = 2'b10,
        FLIT_TAIL   = 2'b11
    } flit_type_e;
    typedef enum logic {ST_IDLE, ST_LOCKED} arb_state_e;
endpackage

// File: rtl/leaf_flit_fifo.sv
// leaf_flit_fifo: show-ahead sync FIFO; writes while full and reads while empty are ignored
module leaf_flit_fifo #(
    parameter int DWIDTH     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] rd_data,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    logic [DWIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic wr, rd;
    assign full = count_q == CW'(FIFO_DEPTH);
    assign empty = count_q == '0;
    assign wr = wr_en && !full;
    assign rd = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr);
        rd_ptr_d = rd_ptr_q + AW'(rd);
        count_d = count_q + CW'(wr) - CW'(rd);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/leaf_uplink_arbiter.sv
// leaf_uplink_arbiter: per-source FIFOs, round-robin arbitration with wormhole lock,
// and a registered one-flit-per-cycle launch into a spine leaf port
module leaf_uplink_arbiter
    import noc_flit_pkg::*;
#(
    parameter int DWIDTH     = FLIT_DWIDTH,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_SRC    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC*DWIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_full,
    output logic [DWIDTH-1:0]         up_data,
    output logic                      up_valid,
    input  logic                      up_full,
    output logic [NUM_SRC-1:0]        drop_err,
    output logic                      proto_err
);
    localparam int SW = $clog2(NUM_SRC);
    logic [NUM_SRC-1:0] full, empty, pop_en;
    logic [DWIDTH-1:0] head [NUM_SRC];
    arb_state_e state_q, state_d;
    logic [SW-1:0] rr_ptr_q, rr_ptr_d, lock_src_q, lock_src_d, sel;
    logic up_valid_q, up_valid_d, proto_err_q, proto_err_d, pop;
    logic [DWIDTH-1:0] up_data_q, up_data_d;
    logic [NUM_SRC-1:0] drop_err_q, drop_err_d;
    flit_type_e ftype;
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
        leaf_flit_fifo #(.DWIDTH(DWIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk    (clk),
            .reset  (reset),
            .wr_en  (src_valid[i]),
            .wr_data(src_data[i*DWIDTH +: DWIDTH]),
            .rd_en  (pop_en[i]),
            .rd_data(head[i]),
            .full   (full[i]),
            .empty  (empty[i])
        );
    end
    assign src_full = full;
    assign up_valid = up_valid_q;
    assign up_data = up_data_q;
    assign drop_err = drop_err_q;
    assign proto_err = proto_err_q;
    // Descending scan so the nearest non-empty source after rr_ptr wins; a locked packet owns the port.
    always_comb begin
        sel = lock_src_q;
        if (state_q == ST_IDLE)
            for (int k = NUM_SRC; k >= 1; k--)
                if (!empty[rr_ptr_q + SW'(k)]) sel = rr_ptr_q + SW'(k);
        pop = !up_full && !empty[sel];
        ftype = flit_type_e'(head[sel][FTYPE_MSB:FTYPE_LSB]);
        pop_en = NUM_SRC'(pop) << sel;
        state_d = state_q;
        rr_ptr_d = rr_ptr_q;
        lock_src_d = lock_src_q;
        up_valid_d = pop;
        up_data_d = pop ? head[sel] : up_data_q;
        drop_err_d = drop_err_q | (src_valid & full);
        proto_err_d = proto_err_q;
        if (pop && state_q == ST_IDLE) begin
            state_d = ftype == FLIT_HEAD ? ST_LOCKED : ST_IDLE;
            lock_src_d = sel;
            rr_ptr_d = ftype == FLIT_HEAD ? rr_ptr_q : sel;
            proto_err_d = proto_err_q | (ftype == FLIT_BODY) | (ftype == FLIT_TAIL);
        end else if (pop) begin
            state_d = ftype == FLIT_TAIL ? ST_IDLE : ST_LOCKED;
            rr_ptr_d = ftype == FLIT_TAIL ? lock_src_q : rr_ptr_q;
            proto_err_d = proto_err_q | (ftype == FLIT_SINGLE) | (ftype == FLIT_HEAD);
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rr_ptr_q <= SW'(NUM_SRC - 1);
            lock_src_q <= '0;
            up_valid_q <= 1'b0;
            up_data_q <= '0;
            drop_err_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_ptr_q <= rr_ptr_d;
            lock_src_q <= lock_src_d;
            up_valid_q <= up_valid_d;
            up_data_q <= up_data_d;
            drop_err_q <= drop_err_d;
            proto_err_q <= proto_err_d;
        end
    end
endmodule

// File: tb/tb_leaf_uplink_arbiter.sv
// tb_leaf_uplink_arbiter: directed scenarios with literal expectations plus random traffic
// compared every cycle against a queue-based model of the arbiter
module tb_leaf_uplink_arbiter;
    localparam int DW = 16;
    localparam int DEPTH = 8;
    logic clk = 0, reset = 1, up_full = 0;
    logic [4*DW-1:0] src_data = '0;
    logic [3:0] src_valid = '0;
    logic [3:0] src_full, drop_err;
    logic [DW-1:0] up_data;
    logic up_valid, proto_err;
    int checks = 0, passed = 0;
    always #5 clk = ~clk;

    leaf_uplink_arbiter #(.DWIDTH(DW), .FIFO_DEPTH(DEPTH), .NUM_SRC(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .src_data (src_data),
        .src_valid(src_valid),
        .src_full (src_full),
        .up_data  (up_data),
        .up_valid (up_valid),
        .up_full  (up_full),
        .drop_err (drop_err),
        .proto_err(proto_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: one queue per source, a packet owner (-1 when free) and the last granted source.
    logic [DW-1:0] mq [4][$];
    int m_owner = -1, m_rr = 3, m_sel;
    logic [DW-1:0] m_f, e_data;
    logic [1:0] m_t;
    logic [3:0] m_wasfull, e_drop, e_full;
    logic e_valid, e_proto;
    bit m_on = 0;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) m_wasfull[i] = mq[i].size() == DEPTH;
        if (reset) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            m_owner = -1; m_rr = 3;
            e_valid = 0; e_data = '0; e_drop = '0; e_proto = 0;
            m_on = 1;
        end else begin
            m_sel = -1;
            if (m_owner >= 0) begin
                if (mq[m_owner].size() > 0) m_sel = m_owner;
            end else begin
                for (int k = 1; k <= 4; k++)
                    if (m_sel < 0 && mq[(m_rr + k) % 4].size() > 0) m_sel = (m_rr + k) % 4;
            end
            e_valid = 0;
            if (!up_full && m_sel >= 0) begin
                m_f = mq[m_sel].pop_front();
                e_valid = 1; e_data = m_f; m_t = m_f[15:14];
                if (m_owner < 0) begin
                    if (m_t == 2'b01) m_owner = m_sel;
                    else begin
                        m_rr = m_sel;
                        if (m_t[1]) e_proto = 1;
                    end
                end else if (m_t == 2'b11) begin
                    m_rr = m_owner; m_owner = -1;
                end else if (m_t != 2'b10) e_proto = 1;
            end
            for (int i = 0; i < 4; i++)
                if (src_valid[i]) begin
                    if (m_wasfull[i]) e_drop[i] = 1;
                    else mq[i].push_back(src_data[i*DW +: DW]);
                end
        end
        for (int i = 0; i < 4; i++) e_full[i] = mq[i].size() == DEPTH;
        #1;
        if (m_on) begin
            chk("model up_valid", 32'(up_valid), 32'(e_valid));
            chk("model up_data", 32'(up_data), 32'(e_data));
            chk("model src_full", 32'(src_full), 32'(e_full));
            chk("model drop_err", 32'(drop_err), 32'(e_drop));
            chk("model proto_err", 32'(proto_err), 32'(e_proto));
        end
    end

    task automatic step(input logic [3:0] v, input logic [63:0] d, input logic uf);
        src_valid = v; src_data = d; up_full = uf;
        @(negedge clk);
        src_valid = '0;
    endtask

    task automatic do_reset();
        reset = 1; src_valid = '0; up_full = 0;
        @(negedge clk);
        reset = 0;
    endtask

    task automatic chk_out(input string name, input logic v, input logic [15:0] d);
        chk({name, " valid"}, 32'(up_valid), 32'(v));
        if (v) chk({name, " data"}, 32'(up_data), 32'(d));
    endtask

    int gr[4];
    logic [3:0] rv;
    logic [63:0] rdat;
    logic [1:0] rt;

    initial begin
        @(negedge clk);
        reset = 0;
        chk("reset up_valid", 32'(up_valid), 0);
        chk("reset up_data", 32'(up_data), 0);
        chk("reset src_full", 32'(src_full), 0);
        chk("reset drop_err", 32'(drop_err), 0);
        chk("reset proto_err", 32'(proto_err), 0);

        // single flit latency
        step(4'b0001, 64'h0A55, 0);
        chk_out("t1 early", 0, 16'h0);
        step(0, 0, 0);
        chk_out("t1 launch", 1, 16'h0A55);
        step(0, 0, 0);
        chk_out("t1 after", 0, 16'h0);

        // four singles at once, twice
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) rdat[i*16 +: 16] = 16'(r * 16 + i + 1);
            step(4'hF, rdat, 0);
            for (int i = 0; i < 4; i++) begin
                step(0, 0, 0);
                chk_out("t2 order", 1, 16'(r * 16 + i + 1));
            end
            step(0, 0, 0);
            chk_out("t2 idle", 0, 16'h0);
        end

        // wormhole packet on src 1 with a competing single on src 2
        do_reset();
        step(4'b0010, {32'h0, 16'h4111, 16'h0}, 0);
        chk_out("t3 c0", 0, 16'h0);
        step(4'b0110, {16'h0, 16'h0222, 16'h8112, 16'h0}, 0);
        chk_out("t3 head", 1, 16'h4111);
        step(4'b0010, {32'h0, 16'h8113, 16'h0}, 0);
        chk_out("t3 body1", 1, 16'h8112);
        step(4'b0010, {32'h0, 16'hC114, 16'h0}, 0);
        chk_out("t3 body2", 1, 16'h8113);
        step(0, 0, 0);
        chk_out("t3 tail", 1, 16'hC114);
        step(0, 0, 0);
        chk_out("t3 single", 1, 16'h0222);
        step(0, 0, 0);
        chk_out("t3 idle", 0, 16'h0);

        // backpressure holds three queued flits
        do_reset();
        step(4'b0111, {16'h0, 16'h0203, 16'h0202, 16'h0201}, 1);
        chk_out("t4 held", 0, 16'h0);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 1);
            chk_out("t4 held", 0, 16'h0);
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0);
            chk_out("t4 release", 1, 16'(16'h0201 + k));
        end
        step(0, 0, 0);
        chk_out("t4 drained", 0, 16'h0);

        // overflow of src 3
        do_reset();
        for (int k = 0; k < 9; k++) begin
            step(4'b1000, {16'(16'h0300 + k), 48'h0}, 1);
            if (k == 7) begin
                chk("t5 full after 8", 32'(src_full[3]), 1);
                chk("t5 no drop yet", 32'(drop_err[3]), 0);
            end
        end
        chk("t5 drop_err", 32'(drop_err), 32'h8);
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0);
            chk_out("t5 drain", 1, 16'(16'h0300 + k));
        end
        step(0, 0, 0);
        chk_out("t5 nothing extra", 0, 16'h0);

        // protocol error, then reset mid-packet
        do_reset();
        step(4'b0001, 64'h8ABC, 0);
        step(0, 0, 0);
        chk_out("t6 stray body", 1, 16'h8ABC);
        chk("t6 proto_err", 32'(proto_err), 1);
        step(4'b0010, {32'h0, 16'h4AAA, 16'h0}, 0);
        step(4'b0010, {32'h0, 16'h8AAB, 16'h0}, 0);
        chk_out("t6 head", 1, 16'h4AAA);
        step(0, 0, 1);
        chk_out("t6 stalled", 0, 16'h0);
        do_reset();
        chk("t6 rst up_valid", 32'(up_valid), 0);
        chk("t6 rst up_data", 32'(up_data), 0);
        chk("t6 rst proto_err", 32'(proto_err), 0);
        chk("t6 rst src_full", 32'(src_full), 0);
        step(0, 0, 0);
        chk_out("t6 fifo emptied", 0, 16'h0);
        step(4'b0100, {16'h0, 16'h0BBB, 32'h0}, 0);
        step(0, 0, 0);
        chk_out("t6 src2 granted", 1, 16'h0BBB);

        // random traffic
        do_reset();
        for (int i = 0; i < 4; i++) gr[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = $urandom_range(0, 599) == 0;
            rv = '0; rdat = '0;
            if (reset) for (int i = 0; i < 4; i++) gr[i] = 0;
            else for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 99) < 35) begin
                    rv[i] = 1;
                    if (gr[i] == 0) begin
                        rt = $urandom_range(0, 1) ? 2'b00 : 2'b01;
                        if (rt == 2'b01) gr[i] = $urandom_range(1, 4);
                    end else begin
                        gr[i]--;
                        rt = gr[i] == 0 ? 2'b11 : 2'b10;
                    end
                    rdat[i*16 +: 16] = {rt, 14'($urandom)};
                end
            step(rv, rdat, $urandom_range(0, 99) < 30);
        end
        reset = 0;
        for (int c = 0; c < 40; c++) step(0, 0, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
